// File: rtl/ifetch_pkg.sv
// ifetch_pkg: opcode map, instruction field positions and FSM states
// shared by the fetch/decode stage.
package ifetch_pkg;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int ABS_HI = 10;
    localparam int REL_HI = 9;

    localparam logic [3:0] OP_RSV0 = 4'hA;
    localparam logic [3:0] OP_RSV1 = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_JSR  = 4'hD;
    localparam logic [3:0] OP_RET  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        FETCH,
        ISSUE,
        HALT
    } state_e;

endpackage

// File: rtl/ifetch_ctrl_if.sv
// ifetch_ctrl_if: program-memory read bus plus the execute-side
// valid/ready handshake of the fetch stage.
interface ifetch_ctrl_if #(
    parameter int ADDR_W  = 11,
    parameter int INSTR_W = 16
);
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_ack;
    logic [INSTR_W-1:0] mem_rdata;
    logic [INSTR_W-1:0] instr_out;
    logic               instr_valid;
    logic               exec_ready;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata,
        output instr_out,
        output instr_valid,
        input  exec_ready
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata,
        input  instr_out,
        input  instr_valid,
        output exec_ready
    );

endinterface

// File: rtl/ifetch_decode.sv
// ifetch_decode: combinational split of the instruction register into
// control-flow flags and address fields.
module ifetch_decode
    import ifetch_pkg::*;
#(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 11,
    parameter int REL_W   = 10
) (
    input  logic [INSTR_W-1:0] ir,
    output logic               is_jmp,
    output logic               is_jsr,
    output logic               is_ret,
    output logic               is_halt,
    output logic               is_rsv,
    output logic [ADDR_W-1:0]  abs_addr,
    output logic [REL_W-1:0]   rel_addr
);

    logic [3:0] op;
    logic       unused_ir11;

    assign op          = ir[OP_HI:OP_LO];
    assign unused_ir11 = ir[11];

    assign is_jmp  = (op == OP_JMP);
    assign is_jsr  = (op == OP_JSR);
    assign is_ret  = (op == OP_RET);
    assign is_halt = (op == OP_HALT);
    assign is_rsv  = (op == OP_RSV0) || (op == OP_RSV1);

    assign abs_addr = ir[ABS_HI:0];
    assign rel_addr = ir[REL_HI:0];

endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: fetch/decode stage driving the PC controls and execute.
// Define IFETCH_TRAP_EN to trap opcodes 0xA/0xB to TRAP_VECTOR.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int ADDR_W      = 11,
    parameter int INSTR_W     = 16,
    parameter int REL_W       = 10,
    parameter int ACK_TIMEOUT = 15
`ifdef IFETCH_TRAP_EN
    ,
    parameter logic [ADDR_W-1:0] TRAP_VECTOR = 11'h7F0
`endif
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] pc,
    ifetch_ctrl_if.master     bus,
    output logic              pc_en,
    output logic              jsr,
    output logic              ret,
    output logic              preload,
    output logic [ADDR_W-1:0] preload_addr,
    output logic [REL_W-1:0]  relative_addr,
    output logic              halted,
    output logic              fetch_err
`ifdef IFETCH_TRAP_EN
    ,
    output logic              trap
`endif
);

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               halted_q, halted_d;
    logic               err_q, err_d;

    logic              dec_jmp;
    logic              dec_jsr;
    logic              dec_ret;
    logic              dec_halt;
    logic              dec_rsv;
    logic [ADDR_W-1:0] dec_abs;
    logic [REL_W-1:0]  dec_rel;

    ifetch_decode #(
        .INSTR_W (INSTR_W),
        .ADDR_W  (ADDR_W),
        .REL_W   (REL_W)
    ) u_decode (
        .ir       (ir_q),
        .is_jmp   (dec_jmp),
        .is_jsr   (dec_jsr),
        .is_ret   (dec_ret),
        .is_halt  (dec_halt),
        .is_rsv   (dec_rsv),
        .abs_addr (dec_abs),
        .rel_addr (dec_rel)
    );

`ifndef IFETCH_TRAP_EN
    logic unused_rsv;
    assign unused_rsv = dec_rsv;
`endif

    // state resets to FETCH, so the request is masked while reset is held
    assign bus.mem_req   = (state_q == FETCH) && reset_n;
    assign bus.mem_addr  = pc;
    assign bus.instr_out = ir_q;
    assign halted        = halted_q;
    assign fetch_err     = err_q;

    always_comb begin
        state_d          = state_q;
        ir_d             = ir_q;
        cnt_d            = cnt_q;
        halted_d         = halted_q;
        err_d            = err_q;
        pc_en            = 1'b0;
        jsr              = 1'b0;
        ret              = 1'b0;
        preload          = 1'b0;
        preload_addr     = '0;
        relative_addr    = '0;
        bus.instr_valid  = 1'b0;
`ifdef IFETCH_TRAP_EN
        trap             = 1'b0;
`endif
        unique case (state_q)
            FETCH: begin
                if (bus.mem_ack) begin
                    ir_d    = bus.mem_rdata;
                    cnt_d   = '0;
                    state_d = ISSUE;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    err_d   = 1'b1;
                    state_d = HALT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ISSUE: begin
                unique case (1'b1)
                    dec_jmp: begin
                        preload      = 1'b1;
                        preload_addr = dec_abs;
                        pc_en        = 1'b1;
                        state_d      = FETCH;
                    end
                    dec_jsr: begin
                        jsr           = 1'b1;
                        relative_addr = dec_rel;
                        pc_en         = 1'b1;
                        state_d       = FETCH;
                    end
                    dec_ret: begin
                        ret     = 1'b1;
                        pc_en   = 1'b1;
                        state_d = FETCH;
                    end
                    dec_halt: begin
                        halted_d = 1'b1;
                        state_d  = HALT;
                    end
`ifdef IFETCH_TRAP_EN
                    dec_rsv: begin
                        preload      = 1'b1;
                        preload_addr = TRAP_VECTOR;
                        pc_en        = 1'b1;
                        trap         = 1'b1;
                        state_d      = FETCH;
                    end
`endif
                    default: begin
                        bus.instr_valid = 1'b1;
                        if (bus.exec_ready) begin
                            pc_en   = 1'b1;
                            state_d = FETCH;
                        end
                    end
                endcase
            end
            HALT: begin
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= FETCH;
            ir_q     <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Fetch/decode stage directly downstream of the program counter.
- Each instruction cycle it:
  - samples `pc` and fetches the 16-bit word from program memory over a req/ack handshake;
  - decodes control-flow opcodes into the PC's `jsr`/`ret`/`preload` controls;
  - forwards all other instructions to execute over a valid/ready handshake.
- Issues a single-cycle `pc_en` strobe that the PC stage uses as its update enable.

Parameters:
- ADDR_W, 11, program address width (matches `pc`).
- INSTR_W, 16, instruction word width.
- REL_W, 10, JSR relative-offset width.
- ACK_TIMEOUT, 15, max cycles in FETCH without `mem_ack` before fault.
- TRAP_VECTOR, 11'h7F0, target of illegal-opcode trap (used only with IFETCH_TRAP_EN).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- pc  in  ADDR_W  current PC value.
- mem_req  out  1  program-memory read request (level).
- mem_addr  out  ADDR_W  read address.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  INSTR_W  read data.
- pc_en  out  1  one-cycle PC update enable.
- jsr  out  1  PC control: call.
- ret  out  1  PC control: return.
- preload  out  1  PC control: absolute load.
- preload_addr  out  ADDR_W  absolute target.
- relative_addr  out  REL_W  call offset.
- instr_out  out  INSTR_W  instruction to execute.
- instr_valid  out  1  `instr_out` valid.
- exec_ready  in  1  execute accepts instruction.
- halted  out  1  HALT executed (sticky).
- fetch_err  out  1  memory timeout (sticky).
- trap  out  1  one-cycle illegal-opcode pulse (IFETCH_TRAP_EN only).

Behaviour:
- Reset (async, `reset_n`=0):
  - state=FETCH; IR=0; timeout counter=0.
  - All outputs 0, except `mem_addr`, which follows `pc`.
  - Reset mid-handshake abandons the fetch. A `mem_ack` arriving while `reset_n`=0 is ignored.
- Instruction word fields:
  - op=IR[15:12];
  - abs=IR[10:0];
  - rel=IR[9:0], unsigned and added by the PC with ADDR_W wrap.
- Opcode map:
  - 0x0–0x9 forward;
  - 0xA–0xB reserved;
  - 0xC JMP;
  - 0xD JSR;
  - 0xE RET;
  - 0xF HALT.
- FETCH state:
  - `mem_req`=1 and `mem_addr`=`pc` (combinational).
  - On `mem_ack`: IR<=`mem_rdata`, counter cleared, go to ISSUE. Minimum latency is 1 cycle (ack in the first FETCH cycle).
  - Without ack, counter increments. On reaching ACK_TIMEOUT: `fetch_err`<=1, go to HALT.
- ISSUE state (outputs decoded from IR):
  - JMP: `preload`=1, `preload_addr`=abs, `pc_en`=1 for exactly one cycle; then FETCH.
  - JSR: `jsr`=1, `relative_addr`=rel, `pc_en`=1 for one cycle; then FETCH.
  - RET: `ret`=1, `pc_en`=1 for one cycle; then FETCH.
  - Forward (0x0–0x9, and 0xA–0xB without the feature):
    - `instr_valid`=1 and `instr_out`=IR, held stable until `exec_ready`.
    - In the handshake cycle `pc_en`=1; then FETCH.
    - If `exec_ready` is already high on ISSUE entry, the handshake completes in 1 cycle.
  - HALT: `halted`<=1 and go to HALT; no `pc_en`.
- Control-output exclusivity: at most one of `jsr`/`ret`/`preload` is high in any cycle. All three are 0 outside ISSUE, and `pc_en` is never high outside ISSUE.
- `pc` is sampled only in FETCH. The PC updates on the edge closing the ISSUE cycle, so the next FETCH sees the new value.
- HALT state: all strobes 0, `mem_req`=0; exit only via reset.
- Throughput: 2 cycles per instruction minimum (FETCH+ISSUE).

Optional Feature:
- IFETCH_TRAP_EN defined:
  - Opcodes 0xA/0xB in ISSUE assert `preload`=1, `preload_addr`=TRAP_VECTOR, `pc_en`=1 and `trap`=1 for one cycle; then FETCH.
  - The instruction is not forwarded.
- IFETCH_TRAP_EN undefined:
  - 0xA/0xB are forwarded like 0x0–0x9.
  - `trap` port absent.

Decomposition:
- Package `ifetch_pkg` holds:
  - opcode constants (OP_JMP, OP_JSR, OP_RET, OP_HALT, OP_RSV0/1);
  - field bit positions;
  - state enum (FETCH, ISSUE, HALT).
- Sub-module `ifetch_decode`: combinational IR→{is_jmp, is_jsr, is_ret, is_halt, is_rsv, abs, rel}; the FSM and counter stay in `ifetch_ctrl`.

Test Plan:
- Reset release with `pc`=0, memory acking in 1 cycle with 16'h1234 -> `mem_req`=1, `mem_addr`=0 in cycle 1; cycle 2 `instr_valid`=1, `instr_out`=16'h1234; `pc_en` pulses once when `exec_ready`=1.
- Fetch word 16'hC123 -> exactly one cycle with `preload`=1, `preload_addr`=11'h123, `pc_en`=1; `instr_valid` stays 0.
- Fetch 16'hD005 at `pc`=10, then 16'hE000 -> `jsr`=1 with `relative_addr`=5, followed later by `ret`=1; each pulse lasts one cycle.
- Forwarded instruction with `exec_ready` low for 4 cycles -> `instr_out` stable, `pc_en`=0 throughout, `pc_en`=1 only in the handshake cycle.
- `mem_ack` held low for 15 cycles -> `fetch_err`=1, `mem_req`=0, FSM parked; 16'hF000 fetched in a separate run -> `halted`=1 and no further `mem_req`.
- Assert `reset_n`=0 mid-FETCH and mid-ISSUE -> outputs clear immediately, without waiting for a clock edge. With IFETCH_TRAP_EN: 16'hA000 -> `trap`=1, `preload_addr`=11'h7F0.
